usb_in_packetizer: RTL
======================

USB_IN_PACKETIZER -- requirements
Module: usb_in_packetizer

Interface
REQ-001 Parameter N_EP_IN, default 1: number of IN endpoints feeding the upstream arbiter (1..16).
REQ-002 Parameter MAX_PKT, default 8: maximum data bytes per DATA packet (1..64).
REQ-003 One clock; reset is synchronous and active-high; ports named i_clk and i_rst.
REQ-004 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_inToken  input  1  one-cycle pulse: a valid IN token addressed to this device was received.
REQ-007 i_arbGrant  input  N_EP_IN  onehot (or zero) grant from the upstream arbiter.
REQ-008 i_arbData  input  8  data byte of the granted endpoint.
REQ-009 o_arbPop  output  N_EP_IN  onehot, one cycle per byte consumed from that endpoint.
REQ-010 o_txValid  output  1  byte offered to the serializer.
REQ-011 o_txData  output  8  byte value; stable while o_txValid && !i_txReady.
REQ-012 o_txLast  output  1  marks the final byte of a packet; qualified by o_txValid.
REQ-013 i_txReady  input  1  serializer accepts; a transfer occurs when o_txValid && i_txReady.
REQ-014 i_hsAck  input  1  one-cycle pulse: host ACK received for the last DATA packet.
REQ-015 i_hsTimeout  input  1  one-cycle pulse: handshake timeout, no ACK received.

Function
REQ-016 FSM states: IDLE, PID, DATA, CRC_LO, CRC_HI, WAIT_HS, NAK.
REQ-017 IDLE + i_inToken with a replay pending: latch the replay endpoint and its length; go to PID; send the same PID and bytes from the replay buffer, without popping upstream.
REQ-018 IDLE + i_inToken, no replay pending, i_arbGrant nonzero: latch epSel = i_arbGrant; go to PID.
REQ-019 IDLE + i_inToken, no replay pending, i_arbGrant zero: go to NAK; send the single byte 0x5A with o_txLast=1; return to IDLE on transfer.
REQ-020 PID byte is 0xC3 (DATA0) when the toggle bit of the selected endpoint is 0, and 0x4B (DATA1) when it is 1.
REQ-021 DATA fresh mode: on each transfer, pulse o_arbPop[epSel], write the byte to the replay buffer, and increment the count.
REQ-022 DATA is left for CRC_LO when count reaches MAX_PKT, or when (i_arbGrant & epSel) is zero at the point a byte would be offered. A packet with zero data bytes is legal.
REQ-023 o_arbPop is never asserted except coincident with a DATA-state transfer; no byte is popped twice or dropped.
REQ-024 CRC16: polynomial 0x8005, init 0xFFFF, LSB-first per byte, over the data bytes only; the complemented result is sent low byte then high byte. The zero-length CRC is 0x00,0x00.
REQ-025 o_txLast=1 only on CRC_HI (and on the NAK byte); after the CRC_HI transfer go to WAIT_HS.
REQ-026 WAIT_HS + i_hsAck: flip the toggle of epSel, clear replay pending, go to IDLE.
REQ-027 WAIT_HS + i_hsTimeout: set replay pending (keep epSel, length and toggle), go to IDLE.
REQ-028 i_hsAck and i_hsTimeout in the same cycle: ACK wins.
REQ-029 i_hsAck or i_hsTimeout outside WAIT_HS is ignored.
REQ-030 i_inToken outside IDLE is ignored.
REQ-031 Latency: PID is offered on the cycle after i_inToken; each subsequent byte is offered on the cycle after the previous transfer. Zero bubbles when i_txReady is held high.

Reset
REQ-032 During reset: o_txValid, o_txLast, o_arbPop and o_txData are 0; state is IDLE; all toggles are 0; replay pending is 0; counters and CRC are cleared.
REQ-033 Reset asserted mid-packet or in WAIT_HS abandons the packet; no pop is issued in the reset cycle; the replay buffer contents become don't-care.

Structure
REQ-034 The shared package holds the PID constants (DATA0, DATA1, NAK), the CRC16 polynomial, init and residual constants, and the FSM state encoding.
REQ-035 A single sub-module usb_crc16 provides byte-wide CRC16 with init/update/result and is reused by the OUT-side checker.
REQ-036 The replay buffer is a MAX_PKT x 8 register array, written in DATA fresh mode and read in replay mode.

Verification
REQ-037 EP0 holds 0x01,0x02,0x03; token, txReady=1 -> C3 01 02 03 + CRC matching a reference model; 3 pops on bit 0; o_txLast only on CRC high byte.
REQ-038 No grant at token -> single byte 0x5A with o_txLast=1; no pops; toggles unchanged.
REQ-039 EP0 grant present with zero bytes available at DATA entry -> C3 00 00; then ACK; next packet on EP0 uses PID 0x4B.
REQ-040 MAX_PKT=8 with 10 bytes queued on EP1 -> first packet carries 8 bytes; after ACK, next token -> 0x4B then remaining 2 bytes.
REQ-041 Timeout after a 4-byte packet, then EP2 gains a grant, then token -> identical PID/bytes/CRC replayed from the original endpoint; zero pops; EP2 is served only after ACK.
REQ-042 Reset asserted in the middle of DATA with random i_txReady -> o_txValid=0 on the following cycle; all toggles are 0; the next token starts with a fresh 0xC3 packet.

Source files
------------

// File: rtl/usb_in_packetizer_pkg.sv
// ============================================================================
// Module  : usb_in_packetizer_pkg
// Purpose : Shared PID, CRC16 and FSM encodings for the USB IN/OUT data path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package usb_in_packetizer_pkg;

    localparam logic [7:0]  c_pid_data0       = 8'hC3;
    localparam logic [7:0]  c_pid_data1       = 8'h4B;
    localparam logic [7:0]  c_pid_nak         = 8'h5A;

    // The register runs LSB-first, so it shifts with the bit-reversed polynomial.
    localparam logic [15:0] c_crc16_poly      = 16'h8005;
    localparam logic [15:0] c_crc16_poly_refl = 16'hA001;
    localparam logic [15:0] c_crc16_init      = 16'hFFFF;
    localparam logic [15:0] c_crc16_residual  = 16'hB001;

    typedef enum logic [2:0] {
        c_st_idle    = 3'd0,
        c_st_pid     = 3'd1,
        c_st_data    = 3'd2,
        c_st_crc_lo  = 3'd3,
        c_st_crc_hi  = 3'd4,
        c_st_wait_hs = 3'd5,
        c_st_nak     = 3'd6
    } state_t;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] v_crc;
        v_crc = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            v_crc = v_crc[0] ? ((v_crc >> 1) ^ c_crc16_poly_refl) : (v_crc >> 1);
        end
        return v_crc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/usb_in_packetizer_crc16.sv
// ============================================================================
// Module  : usb_crc16
// Purpose : Byte-wide USB CRC16 accumulator with init/update and a ready-to-send result.
// Revision: 1.0
// ============================================================================
`default_nettype none

module usb_crc16
    import usb_in_packetizer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_init,
    input  logic        i_update,
    input  logic [7:0]  i_data,
    output logic [15:0] o_result
);

    logic [15:0] r_crc;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_init) begin
            r_crc <= c_crc16_init;
        end else if (i_update) begin
            r_crc <= crc16_byte(r_crc, i_data);
        end
    end

    assign o_result = ~r_crc;

endmodule

`default_nettype wire

// File: rtl/usb_in_packetizer.sv
// ============================================================================
// Module  : usb_in_packetizer
// Purpose : Builds USB IN DATA0/DATA1 packets from arbitrated endpoint bytes, with replay on timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module usb_in_packetizer
    import usb_in_packetizer_pkg::*;
#(
    parameter int N_EP_IN = 1,
    parameter int MAX_PKT = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_inToken,
    input  logic [N_EP_IN-1:0] i_arbGrant,
    input  logic [7:0]         i_arbData,
    output logic [N_EP_IN-1:0] o_arbPop,
    output logic               o_txValid,
    output logic [7:0]         o_txData,
    output logic               o_txLast,
    input  logic               i_txReady,
    input  logic               i_hsAck,
    input  logic               i_hsTimeout
);

    localparam int c_cnt_w = $clog2(MAX_PKT + 1);
    localparam int c_idx_w = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_PKT);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [N_EP_IN-1:0]   r_ep_sel;
    logic [N_EP_IN-1:0]   r_toggle;
    logic                 r_replay_pend;
    logic                 r_replay_mode;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   r_len;
    logic [7:0]           r_buf [MAX_PKT];

    logic                 w_start;
    logic                 w_tog;
    logic                 w_avail;
    logic                 w_data_xfer;
    logic                 w_pop_en;
    logic                 w_valid;
    logic                 w_last;
    logic [7:0]           w_data;
    logic [7:0]           w_buf_byte;
    logic [c_idx_w-1:0]   w_idx;
    logic [15:0]          w_crc;

    assign w_start    = (r_state == c_st_idle) && i_inToken;
    assign w_tog      = |(r_toggle & r_ep_sel);
    assign w_idx      = r_cnt[c_idx_w-1:0];
    assign w_buf_byte = r_buf[w_idx];
    assign w_avail    = r_replay_mode ? (r_cnt < r_len)
                                      : ((r_cnt < c_max_cnt) && |(i_arbGrant & r_ep_sel));
    assign w_pop_en   = w_data_xfer && !r_replay_mode;

    // When no data byte is available in DATA the CRC low byte is offered in the
    // same cycle, so a packet end costs no bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_last      = 1'b0;
        w_data      = 8'h00;
        w_data_xfer = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (i_inToken) begin
                    w_state_nxt = (r_replay_pend || |i_arbGrant) ? c_st_pid : c_st_nak;
                end
            end
            c_st_pid: begin
                w_valid = 1'b1;
                w_data  = w_tog ? c_pid_data1 : c_pid_data0;
                if (i_txReady) w_state_nxt = c_st_data;
            end
            c_st_data: begin
                w_valid = 1'b1;
                if (w_avail) begin
                    w_data      = r_replay_mode ? w_buf_byte : i_arbData;
                    w_data_xfer = i_txReady && !i_rst;
                end else begin
                    w_data      = w_crc[7:0];
                    w_state_nxt = i_txReady ? c_st_crc_hi : c_st_crc_lo;
                end
            end
            c_st_crc_lo: begin
                w_valid = 1'b1;
                w_data  = w_crc[7:0];
                if (i_txReady) w_state_nxt = c_st_crc_hi;
            end
            c_st_crc_hi: begin
                w_valid = 1'b1;
                w_last  = 1'b1;
                w_data  = w_crc[15:8];
                if (i_txReady) w_state_nxt = c_st_wait_hs;
            end
            c_st_wait_hs: begin
                if (i_hsAck || i_hsTimeout) w_state_nxt = c_st_idle;
            end
            c_st_nak: begin
                w_valid = 1'b1;
                w_last  = 1'b1;
                w_data  = c_pid_nak;
                if (i_txReady) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= c_st_idle;
            r_ep_sel      <= '0;
            r_toggle      <= '0;
            r_replay_pend <= 1'b0;
            r_replay_mode <= 1'b0;
            r_cnt         <= '0;
            r_len         <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_cnt <= '0;
                if (r_replay_pend) begin
                    r_replay_mode <= 1'b1;
                end else begin
                    r_replay_mode <= 1'b0;
                    if (|i_arbGrant) r_ep_sel <= i_arbGrant;
                end
            end else if (w_data_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == c_st_wait_hs) begin
                if (i_hsAck) begin
                    r_toggle      <= r_toggle ^ r_ep_sel;
                    r_replay_pend <= 1'b0;
                end else if (i_hsTimeout) begin
                    r_replay_pend <= 1'b1;
                    r_len         <= r_cnt;
                end
            end
        end
    end

    // Replay storage carries no reset; its content only matters while a replay is pending.
    always_ff @(posedge i_clk) begin
        if (w_pop_en) begin
            r_buf[w_idx] <= i_arbData;
        end
    end

    usb_crc16 u_crc16 (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_init   (w_start),
        .i_update (w_data_xfer),
        .i_data   (w_data),
        .o_result (w_crc)
    );

    assign o_arbPop  = r_ep_sel & {N_EP_IN{w_pop_en}};
    assign o_txValid = w_valid && !i_rst;
    assign o_txLast  = w_last && !i_rst;
    assign o_txData  = i_rst ? 8'h00 : w_data;

endmodule

`default_nettype wire
